// File: rtl/bus_slave_mem.sv
// Word-addressed memory slave for the shared simple bus: registered read data,
// one-cycle error pulse on out-of-range access, and a saturating write counter.
module bus_slave_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_err,
  output logic [7:0]        s_wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_W;

  // Handshake: s_sel alone qualifies a transfer; every selected cycle is accepted
  // (no wait states), and s_wr/s_addr/s_din are ignored whenever s_sel=0.
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               err_q, err_d;
  logic [7:0]         wr_cnt_q, wr_cnt_d;
  logic               in_range;
  logic               wr_en;
  logic               rd_en;
  logic [DEPTH_W-1:0] idx;

  always_comb begin
    // Shifting out the index bits leaves zero for every address when DEPTH_W==ADDR_W.
    in_range = ((s_addr >> DEPTH_W) == '0);
    idx      = s_addr[DEPTH_W-1:0];
    wr_en    = s_sel && s_wr && in_range;
    rd_en    = s_sel && !s_wr && in_range;

    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    dout_d   = '0;
    err_d    = s_sel && !in_range;

    if (wr_en) begin
      mem_d[idx] = s_din;
      if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
    end
    if (rd_en) dout_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      mem_q    <= mem_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign s_dout   = dout_q;
  assign s_err    = err_q;
  assign s_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed and random bench for bus_slave_mem against a simple array model.
module tb_bus_slave_mem;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        s_err;
  logic [7:0]  s_wr_cnt;

  int checks;
  int failures;

  // Reference model: 32-word memory plus a write count clamped at 255.
  logic [31:0] ref_mem [32];
  int          ref_cnt;
  logic [31:0] exp_q [$];

  bus_slave_mem dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s_sel    (s_sel),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_din    (s_din),
    .s_dout   (s_dout),
    .s_err    (s_err),
    .s_wr_cnt (s_wr_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one bus cycle, let the edge happen, then compare all outputs with the model.
  task automatic access(input logic sel, input logic wr, input logic [7:0] addr,
                        input logic [31:0] din, input string tag);
    logic [31:0] exp_dout;
    logic        exp_err;
    s_sel  = sel;
    s_wr   = wr;
    s_addr = addr;
    s_din  = din;
    @(posedge clk);
    #1;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      ref_cnt  = 0;
      exp_dout = '0;
      exp_err  = 1'b0;
    end else begin
      exp_err  = sel && (addr >= 8'd32);
      exp_dout = (sel && !wr && addr < 8'd32) ? ref_mem[addr[4:0]] : 32'h0;
      if (sel && wr && addr < 8'd32) begin
        ref_mem[addr[4:0]] = din;
        ref_cnt = (ref_cnt >= 255) ? 255 : ref_cnt + 1;
      end
    end
    exp_q.push_back(exp_dout);
    check({tag, "_dout"}, s_dout, exp_q.pop_front());
    check({tag, "_err"}, {31'b0, s_err}, {31'b0, exp_err});
    check({tag, "_cnt"}, {24'b0, s_wr_cnt}, ref_cnt);
  endtask

  task automatic idle(input string tag);
    access(1'b0, 1'b0, 8'h00, 32'h0, tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ref_cnt  = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    reset_n = 1'b0;
    s_sel = 0; s_wr = 0; s_addr = 0; s_din = 0;

    // Reset state
    access(1'b0, 1'b0, 8'h00, 32'h0, "reset");
    access(1'b0, 1'b0, 8'h00, 32'h0, "reset2");
    reset_n = 1'b1;
    check("reset_dout_const", s_dout, 32'h0);
    check("reset_cnt_const", {24'b0, s_wr_cnt}, 32'd0);

    // All locations read zero after reset, back-to-back
    for (int a = 0; a < 32; a++) access(1'b1, 1'b0, a[7:0], 32'h0, "rd_clear");
    check("rd_clear_last", s_dout, 32'h0);

    // Write then immediate read of same address
    access(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, "wr05");
    access(1'b1, 1'b0, 8'h05, 32'h0, "rd05");
    check("rd05_const", s_dout, 32'hDEADBEEF);
    check("rd05_cnt_const", {24'b0, s_wr_cnt}, 32'd1);
    idle("rd05_idle");

    // Out-of-range write and read
    access(1'b1, 1'b1, 8'h40, 32'h11111111, "oor_wr");
    check("oor_wr_err_const", {31'b0, s_err}, 32'd1);
    access(1'b1, 1'b0, 8'h40, 32'h0, "oor_rd");
    idle("oor_idle");
    access(1'b1, 1'b0, 8'h00, 32'h0, "oor_mem0");
    check("oor_mem0_const", s_dout, 32'h0);

    // Counter saturation and last-write-wins
    for (int i = 0; i < 300; i++) access(1'b1, 1'b1, 8'(i % 32), 32'(i), "wr300");
    check("sat_cnt_const", {24'b0, s_wr_cnt}, 32'd255);
    for (int a = 0; a < 32; a++) access(1'b1, 1'b0, a[7:0], 32'h0, "rd300");
    access(1'b1, 1'b0, 8'h0B, 32'h0, "rd0b");
    check("rd0b_const", s_dout, 32'd299);

    // Write discarded during reset
    access(1'b1, 1'b1, 8'h1F, 32'hA5A5A5A5, "wr1f");
    reset_n = 1'b0;
    access(1'b1, 1'b1, 8'h1E, 32'h12345678, "rst_wr");
    reset_n = 1'b1;
    access(1'b1, 1'b0, 8'h1E, 32'h0, "rd1e");
    check("rd1e_const", s_dout, 32'h0);
    access(1'b1, 1'b0, 8'h1F, 32'h0, "rd1f");
    check("rd1f_const", s_dout, 32'h0);
    check("rst_cnt_const", {24'b0, s_wr_cnt}, 32'd0);

    // Alternating read / idle
    access(1'b1, 1'b1, 8'h03, 32'h00000077, "wr03");
    for (int k = 0; k < 4; k++) begin
      access(1'b1, 1'b0, 8'h03, 32'h0, "alt_rd");
      check("alt_rd_const", s_dout, 32'h77);
      idle("alt_idle");
      check("alt_idle_const", s_dout, 32'h0);
    end

    // Unselected cycles with junk on the other inputs
    for (int k = 0; k < 8; k++)
      access(1'b0, 1'($urandom), 8'($urandom), $urandom, "unsel");

    // Random traffic including out-of-range addresses
    for (int k = 0; k < 400; k++)
      access(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 47)),
             $urandom, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_slave_mem.md
Name: bus_slave_mem

Overview:
- Word-addressed memory slave on the shared simple bus. It sits downstream of the two-master arbiter and the master-side mux.
- It receives the muxed master request (select, write, address, write data) and returns registered read data and an error pulse.
- It is the responder end of the bus protocol the arbiter grants access to.
- Read data is zero when the slave is not read, so multiple slaves can be OR-combined into the master read path.

Parameters:
- DATA_W, 32, data bus width in bits.
- ADDR_W, 8, bus address width in bits (word address).
- DEPTH_W, 5, log2 of the memory depth in words (default 32 words); must be <= ADDR_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- s_sel  in  1  slave select from the address decoder; qualifies the access.
- s_wr  in  1  1 = write, 0 = read; valid when s_sel=1.
- s_addr  in  ADDR_W  word address.
- s_din  in  DATA_W  write data.
- s_dout  out  DATA_W  registered read data.
- s_err  out  1  registered one-cycle error pulse for an out-of-range access.
- s_wr_cnt  out  8  count of accepted writes since reset; saturates at 255.

Behaviour:
- Reset: on a rising edge of clk with reset_n=0:
  - every memory word is set to 0;
  - s_dout=0, s_err=0, s_wr_cnt=0.
  - Reset takes priority over any access sampled in the same cycle. A write presented in a reset cycle is discarded.
- In-range condition: s_addr[ADDR_W-1:DEPTH_W]==0. The index is s_addr[DEPTH_W-1:0]. When DEPTH_W==ADDR_W, every address is in range.
- Write (s_sel=1, s_wr=1, in range):
  - mem[index] <= s_din at the edge;
  - s_wr_cnt increments by 1, holding at 255;
  - s_dout <= 0 next cycle, s_err <= 0.
- Read (s_sel=1, s_wr=0, in range):
  - s_dout <= mem[index] at the edge, i.e. valid the cycle after the request (1-cycle latency);
  - s_err <= 0.
- Out-of-range access (s_sel=1, either direction):
  - memory and s_wr_cnt are unchanged;
  - s_dout <= 0;
  - s_err <= 1 for exactly one cycle per offending request cycle.
- Idle (s_sel=0): s_dout <= 0 and s_err <= 0. s_wr, s_addr and s_din are don't-care.
- Back-to-back accesses are allowed every cycle; there are no wait states and no handshake beyond s_sel.
- Write followed by a read of the same address in the next cycle returns the new data. The write has updated mem at the prior edge.
- Read and write can never coincide (single s_wr), so there is no same-cycle read/write hazard.
- Master switch: a grant change on the arbiter between cycles needs no special handling. Each cycle is an independent transaction.
- Reset mid-sequence: a read issued in the cycle before reset asserts may not appear. After reset, s_dout=0 and all locations read 0.
- X on s_addr or s_wr while s_sel=0 must not affect memory or outputs.

Test Plan:
- Reset, then read addresses 0x00..0x1F back-to-back -> s_dout=0 each cycle after the request; s_err=0; s_wr_cnt=0.
- Write 0xDEADBEEF to 0x05, next cycle read 0x05 -> s_dout=0xDEADBEEF one cycle after the read request; s_wr_cnt=1; s_dout returns to 0 the cycle after, with s_sel=0.
- Write 0x11111111 to 0x40 (out of range), then read 0x40 -> s_err=1 for one cycle after each request; s_dout=0; s_wr_cnt unchanged; mem[0x00] still 0.
- 300 consecutive writes of value i to address i%32, then read all 32 -> s_wr_cnt saturates at 255; each address reads its last written value (e.g. addr 0x0B = 299).
- Write 0xA5A5A5A5 to 0x1F, assert reset_n=0 for one cycle concurrent with a write of 0x12345678 to 0x1E, then read 0x1E and 0x1F -> both read 0; s_wr_cnt=0.
- Alternate s_sel=1 read of 0x03 (holding 0x00000077) with s_sel=0 cycles -> s_dout toggles 0x77 / 0 with exactly one cycle of latency.
